seg7_scan_driver: RTL and testbench

- Drives the Basys3 4-digit, common-anode, multiplexed 7-segment display.
- Consumes a 16-bit hex value, per-digit enables and decimal points from the soc (e.g. a GPIO port or peripheral register).
- Time-multiplexes the digits, with a ghosting guard at the start of each digit slot.
- New display data is double-buffered and committed only at frame boundaries, so the display never tears.

---
 rtl/seg7_scan_driver.sv | 179 +++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit common-anode 7-segment driver with a per-slot ghosting blank and
// frame-boundary double buffering. Optional brightness PWM: define SEG7_BRIGHTNESS_EN.
module seg7_scan_driver #(
    parameter int CLK_FREQ     = 10_000_000,
    parameter int REFRESH_HZ   = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value_i,
    input  logic [3:0]  en_i,
    input  logic [3:0]  dp_i,
    input  logic        load_i,
`ifdef SEG7_BRIGHTNESS_EN
    input  logic [3:0]  bright_i,
`endif
    output logic        pending_o,
    output logic        frame_o,
    output logic [6:0]  seg_o,
    output logic [3:0]  an_o,
    output logic        dp_o
);

    localparam int DWELL = CLK_FREQ / (4 * REFRESH_HZ);
    localparam int CW    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_C  = CW'(BLANK_CYCLES);

    generate
        if (DWELL <= BLANK_CYCLES) begin : g_bad_dwell
            $error("seg7_scan_driver: DWELL (%0d) must exceed BLANK_CYCLES (%0d)", DWELL, BLANK_CYCLES);
        end
    endgenerate

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    dig_q, dig_d;
    logic [15:0]   pval_q, pval_d, aval_q, aval_d;
    logic [3:0]    pen_q, pen_d, aen_q, aen_d;
    logic [3:0]    pdp_q, pdp_d, adp_q, adp_d;
    logic          pend_q, pend_d;
    logic          frame_q, frame_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          dp_q, dp_d;
`ifdef SEG7_BRIGHTNESS_EN
    logic [3:0]    pbr_q, pbr_d, abr_q, abr_d;
    logic [CW+3:0] drive_off;
`endif

    logic       wrap;
    logic       frame_edge;
    logic       drive;
    logic [3:0] nibble;
    logic [3:0] dig_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sel
            assign dig_sel[gi] = (dig_q == 2'(gi));
        end
    endgenerate

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        wrap       = (cnt_q == CNT_LAST);
        frame_edge = wrap && (dig_q == 2'd3);
        cnt_d      = wrap ? '0 : cnt_q + 1'b1;
        dig_d      = wrap ? dig_q + 2'd1 : dig_q;
        frame_d    = frame_edge;

        pval_d = pval_q;
        pen_d  = pen_q;
        pdp_d  = pdp_q;
        pend_d = pend_q;
        aval_d = aval_q;
        aen_d  = aen_q;
        adp_d  = adp_q;
`ifdef SEG7_BRIGHTNESS_EN
        pbr_d  = pbr_q;
        abr_d  = abr_q;
`endif
        // Commit reads the pre-cycle pending copy; a same-cycle load then refills pending.
        if (frame_edge && pend_q) begin
            aval_d = pval_q;
            aen_d  = pen_q;
            adp_d  = pdp_q;
`ifdef SEG7_BRIGHTNESS_EN
            abr_d  = pbr_q;
`endif
            pend_d = 1'b0;
        end
        if (load_i) begin
            pval_d = value_i;
            pen_d  = en_i;
            pdp_d  = dp_i;
`ifdef SEG7_BRIGHTNESS_EN
            pbr_d  = bright_i;
`endif
            pend_d = 1'b1;
        end

        nibble = aval_q[{dig_q, 2'b00} +: 4];
        drive  = (cnt_q >= BLANK_C) && aen_q[dig_q];
`ifdef SEG7_BRIGHTNESS_EN
        drive_off = {4'b0000, cnt_q} - (CW+4)'(BLANK_CYCLES);
        drive     = drive && (drive_off[3:0] <= abr_q);
`endif
        an_d  = drive ? ~dig_sel : 4'b1111;
        seg_d = drive ? hex7(nibble) : 7'b1111111;
        dp_d  = drive ? ~adp_q[dig_q] : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            dig_q   <= 2'd0;
            pval_q  <= 16'h0000;
            pen_q   <= 4'h0;
            pdp_q   <= 4'h0;
            pend_q  <= 1'b0;
            aval_q  <= 16'h0000;
            aen_q   <= 4'h0;
            adp_q   <= 4'h0;
            frame_q <= 1'b0;
            seg_q   <= 7'b1111111;
            an_q    <= 4'b1111;
            dp_q    <= 1'b1;
`ifdef SEG7_BRIGHTNESS_EN
            pbr_q   <= 4'hF;
            abr_q   <= 4'hF;
`endif
        end else begin
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            pval_q  <= pval_d;
            pen_q   <= pen_d;
            pdp_q   <= pdp_d;
            pend_q  <= pend_d;
            aval_q  <= aval_d;
            aen_q   <= aen_d;
            adp_q   <= adp_d;
            frame_q <= frame_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            dp_q    <= dp_d;
`ifdef SEG7_BRIGHTNESS_EN
            pbr_q   <= pbr_d;
            abr_q   <= abr_d;
`endif
        end
    end

    assign pending_o = pend_q;
    assign frame_o   = frame_q;
    assign seg_o     = seg_q;
    assign an_o      = an_q;
    assign dp_o      = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DWELL = 10, BLANK_CYCLES = 2 (40-cycle frame).
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value_i = 16'h0000;
    logic [3:0]  en_i = 4'h0;
    logic [3:0]  dp_i = 4'h0;
    logic        load_i = 1'b0;
`ifdef SEG7_BRIGHTNESS_EN
    logic [3:0]  bright_i = 4'hF;
`endif
    logic        pending_o;
    logic        frame_o;
    logic [6:0]  seg_o;
    logic [3:0]  an_o;
    logic        dp_o;

    int checks = 0;
    int errors = 0;

    seg7_scan_driver #(
        .CLK_FREQ    (4000),
        .REFRESH_HZ  (100),
        .BLANK_CYCLES(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .value_i  (value_i),
        .en_i     (en_i),
        .dp_i     (dp_i),
        .load_i   (load_i),
`ifdef SEG7_BRIGHTNESS_EN
        .bright_i (bright_i),
`endif
        .pending_o(pending_o),
        .frame_o  (frame_o),
        .seg_o    (seg_o),
        .an_o     (an_o),
        .dp_o     (dp_o)
    );

    always #5 clk = ~clk;

    // Leaves the bench at the negedge of the cycle where frame_o is high.
    task automatic wait_frame(input string tag);
        bit seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (frame_o === 1'b1) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_frame_timeout: frame_o=%b required 1 within 100 cycles", tag, frame_o);
        end
    endtask

    task automatic test_reset();
        int n = 0;
        bit dark = 1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks += 5;
        if (an_o !== 4'b1111)     begin errors++; $display("FAIL reset_an: got %b required 1111", an_o); end
        if (seg_o !== 7'b1111111) begin errors++; $display("FAIL reset_seg: got %b required 1111111", seg_o); end
        if (dp_o !== 1'b1)        begin errors++; $display("FAIL reset_dp: got %b required 1", dp_o); end
        if (pending_o !== 1'b0)   begin errors++; $display("FAIL reset_pending: got %b required 0", pending_o); end
        if (frame_o !== 1'b0)     begin errors++; $display("FAIL reset_frame: got %b required 0", frame_o); end
        rst = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            n = i;
            if (an_o !== 4'b1111) dark = 0;
            if (frame_o === 1'b1) break;
        end
        checks += 2;
        if (n != 40) begin errors++; $display("FAIL reset_first_frame: got %0d cycles required 40", n); end
        if (!dark)   begin errors++; $display("FAIL reset_dark: an_o went low, required 1111 throughout"); end
        $display("test_reset: first frame after %0d cycles", n);
    endtask

    task automatic test_basic();
        logic [3:0] ea;
        logic [6:0] es;
        logic       ed;
        int slot, c;
        repeat (2) @(negedge clk);
        value_i = 16'h1234; en_i = 4'b1111; dp_i = 4'b0001; load_i = 1'b1;
        @(negedge clk);
        load_i = 1'b0;
        checks++;
        if (pending_o !== 1'b1) begin errors++; $display("FAIL basic_pending_set: got %b required 1", pending_o); end
        repeat (36) @(negedge clk);
        checks += 2;
        if (pending_o !== 1'b1) begin errors++; $display("FAIL basic_pending_hold: got %b required 1", pending_o); end
        if (frame_o !== 1'b0)   begin errors++; $display("FAIL basic_early_frame: got %b required 0", frame_o); end
        @(negedge clk);
        checks += 2;
        if (frame_o !== 1'b1)   begin errors++; $display("FAIL basic_frame: got %b required 1", frame_o); end
        if (pending_o !== 1'b0) begin errors++; $display("FAIL basic_pending_clr: got %b required 0", pending_o); end
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            slot = (j - 1) / 10;
            c    = (j - 1) % 10;
            ea = 4'b1111; es = 7'b1111111; ed = 1'b1;
            if (c >= 2) begin
                case (slot)
                    0: begin ea = 4'b1110; es = 7'b0011001; ed = 1'b0; end
                    1: begin ea = 4'b1101; es = 7'b0110000; end
                    2: begin ea = 4'b1011; es = 7'b0100100; end
                    default: begin ea = 4'b0111; es = 7'b1111001; end
                endcase
            end
            checks += 4;
            if (an_o !== ea)  begin errors++; $display("FAIL basic_an j=%0d: got %b required %b", j, an_o, ea); end
            if (seg_o !== es) begin errors++; $display("FAIL basic_seg j=%0d: got %b required %b", j, seg_o, es); end
            if (dp_o !== ed)  begin errors++; $display("FAIL basic_dp j=%0d: got %b required %b", j, dp_o, ed); end
            if (frame_o !== (j == 40)) begin errors++; $display("FAIL basic_frame_pulse j=%0d: got %b required %b", j, frame_o, (j == 40)); end
        end
        $display("test_basic: displayed 1234 over one frame");
    endtask

    task automatic test_enable();
        logic [3:0] ea;
        logic [6:0] es;
        int slot, c;
        @(negedge clk);
        value_i = 16'h8888; en_i = 4'b0101; dp_i = 4'b0000; load_i = 1'b1;
        @(negedge clk);
        load_i = 1'b0;
        wait_frame("enable");
        for (int j = 1; j <= 120; j++) begin
            @(negedge clk);
            slot = ((j - 1) / 10) % 4;
            c    = (j - 1) % 10;
            ea = 4'b1111; es = 7'b1111111;
            if (c >= 2 && slot == 0) begin ea = 4'b1110; es = 7'b0000000; end
            if (c >= 2 && slot == 2) begin ea = 4'b1011; es = 7'b0000000; end
            checks += 3;
            if (an_o !== ea)  begin errors++; $display("FAIL enable_an j=%0d: got %b required %b", j, an_o, ea); end
            if (seg_o !== es) begin errors++; $display("FAIL enable_seg j=%0d: got %b required %b", j, seg_o, es); end
            if (dp_o !== 1'b1) begin errors++; $display("FAIL enable_dp j=%0d: got %b required 1", j, dp_o); end
        end
        $display("test_enable: 8888 with mask 0101 over three frames");
    endtask

    task automatic test_collision();
        en_i = 4'b1111; dp_i = 4'b0000;
        repeat (5) @(negedge clk);
        value_i = 16'hAAAA; load_i = 1'b1;
        @(negedge clk);
        load_i = 1'b0;
        repeat (4) @(negedge clk);
        value_i = 16'hBBBB; load_i = 1'b1;
        @(negedge clk);
        load_i = 1'b0;
        repeat (28) @(negedge clk);
        value_i = 16'hCCCC; load_i = 1'b1;
        checks++;
        if (frame_o !== 1'b0) begin errors++; $display("FAIL coll_pre_frame: got %b required 0", frame_o); end
        @(negedge clk);
        load_i = 1'b0;
        checks += 2;
        if (frame_o !== 1'b1)   begin errors++; $display("FAIL coll_frame1: got %b required 1", frame_o); end
        if (pending_o !== 1'b1) begin errors++; $display("FAIL coll_pending_stay: got %b required 1", pending_o); end
        repeat (5) @(negedge clk);
        checks += 3;
        if (an_o !== 4'b1110)     begin errors++; $display("FAIL coll_b_an: got %b required 1110", an_o); end
        if (seg_o !== 7'b0000011) begin errors++; $display("FAIL coll_b_seg: got %b required 0000011", seg_o); end
        if (dp_o !== 1'b1)        begin errors++; $display("FAIL coll_b_dp: got %b required 1", dp_o); end
        repeat (35) @(negedge clk);
        checks += 2;
        if (frame_o !== 1'b1)   begin errors++; $display("FAIL coll_frame2: got %b required 1", frame_o); end
        if (pending_o !== 1'b0) begin errors++; $display("FAIL coll_pending_clr: got %b required 0", pending_o); end
        repeat (5) @(negedge clk);
        checks += 2;
        if (an_o !== 4'b1110)     begin errors++; $display("FAIL coll_c_an: got %b required 1110", an_o); end
        if (seg_o !== 7'b1000110) begin errors++; $display("FAIL coll_c_seg: got %b required 1000110", seg_o); end
        repeat (20) @(negedge clk);
        checks += 2;
        if (an_o !== 4'b1011)     begin errors++; $display("FAIL coll_c2_an: got %b required 1011", an_o); end
        if (seg_o !== 7'b1000110) begin errors++; $display("FAIL coll_c2_seg: got %b required 1000110", seg_o); end
        $display("test_collision: AAAA/BBBB then CCCC on boundary");
    endtask

    task automatic test_midreset();
        wait_frame("midreset");
        repeat (5) @(negedge clk);
        value_i = 16'h1111; load_i = 1'b1;
        @(negedge clk);
        load_i = 1'b0;
        checks++;
        if (pending_o !== 1'b1) begin errors++; $display("FAIL mid_pending_set: got %b required 1", pending_o); end
        repeat (18) @(negedge clk);
        checks += 2;
        if (an_o !== 4'b1011)     begin errors++; $display("FAIL mid_pre_an: got %b required 1011", an_o); end
        if (seg_o !== 7'b1000110) begin errors++; $display("FAIL mid_pre_seg: got %b required 1000110", seg_o); end
        rst = 1'b1;
        @(negedge clk);
        checks += 5;
        if (an_o !== 4'b1111)     begin errors++; $display("FAIL mid_an: got %b required 1111", an_o); end
        if (seg_o !== 7'b1111111) begin errors++; $display("FAIL mid_seg: got %b required 1111111", seg_o); end
        if (dp_o !== 1'b1)        begin errors++; $display("FAIL mid_dp: got %b required 1", dp_o); end
        if (pending_o !== 1'b0)   begin errors++; $display("FAIL mid_pending: got %b required 0", pending_o); end
        if (frame_o !== 1'b0)     begin errors++; $display("FAIL mid_frame: got %b required 0", frame_o); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            checks += 3;
            if (an_o !== 4'b1111)   begin errors++; $display("FAIL mid_dark i=%0d: got %b required 1111", i, an_o); end
            if (pending_o !== 1'b0) begin errors++; $display("FAIL mid_no_commit i=%0d: got %b required 0", i, pending_o); end
            if (frame_o !== (i % 40 == 0)) begin errors++; $display("FAIL mid_frame_pulse i=%0d: got %b required %b", i, frame_o, (i % 40 == 0)); end
        end
        $display("test_midreset: display dark after mid-frame reset");
    endtask

`ifdef SEG7_BRIGHTNESS_EN
    task automatic test_brightness();
        @(negedge clk);
        value_i = 16'h0000; en_i = 4'b0001; dp_i = 4'b0000; bright_i = 4'h0; load_i = 1'b1;
        @(negedge clk);
        load_i = 1'b0;
        wait_frame("bright");
        repeat (3) @(negedge clk);
        checks += 2;
        if (an_o !== 4'b1110)     begin errors++; $display("FAIL bright_on_an: got %b required 1110", an_o); end
        if (seg_o !== 7'b1000000) begin errors++; $display("FAIL bright_on_seg: got %b required 1000000", seg_o); end
        @(negedge clk);
        checks += 3;
        if (an_o !== 4'b1111)     begin errors++; $display("FAIL bright_off_an: got %b required 1111", an_o); end
        if (seg_o !== 7'b1111111) begin errors++; $display("FAIL bright_off_seg: got %b required 1111111", seg_o); end
        if (dp_o !== 1'b1)        begin errors++; $display("FAIL bright_off_dp: got %b required 1", dp_o); end
        $display("test_brightness: bright=0 gives a single lit drive cycle");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_enable();
        test_collision();
        test_midreset();
`ifdef SEG7_BRIGHTNESS_EN
        test_brightness();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
